chad_intc: RTL and testbench
============================

# chad_intc

Interrupt controller feeding the chad core's `irq`/`ivec` inputs and consuming its `iack` strobe. It synchronizes up to 15 asynchronous sources, latches edges or tracks levels per source, masks and prioritizes them, and presents one vector in the range 1..15. Vector 0 is the reset vector and is never issued. The core configures the block through its I/O write and read strobes.

## Interface
- `WIDTH`, 18: core cell width, 16..32; sets the width of the I/O data ports.
- `NSRC`, 8: number of sources, 1..15. Source i maps to vector i+1.
- `clk` in 1: clock.
- `resetq` in 1: reset, asynchronous, active-low.
- `hold` in 1: core wait state. `iack` is ignored while high.
- `src` in NSRC: raw asynchronous interrupt lines.
- `io_sel` in 1: block select, decoded from the I/O address upstream.
- `io_addr` in 3: register select.
- `io_wr` in 1: I/O write strobe from the core.
- `io_wdata` in WIDTH: write data (core `dout`).
- `io_rdata` out WIDTH: read data, driven to the core `io_din` mux.
- `irq` out 1: interrupt request.
- `ivec` out 4: vector that accompanies `irq`.
- `iack` in 1: interrupt acknowledge from the core.

## Operation
- **Input conditioning.** Each source passes through a 2-flop synchronizer (s1, s2) and is XORed with POL to give a normalized level n. A previous-level flop p follows n. Rise = n & ~p.
- **Registers.** Bit i corresponds to source i. Unused upper bits read 0.
  - 0 PEND: read. Writing 1 clears the bit (W1C).
  - 1 EN: read/write.
  - 2 MODE: read/write. 0 = edge, 1 = level.
  - 3 POL: read/write. 1 = active-low.
  - 4 GIE: bit0 is the global enable.
  - 5 SET: write-only. Writing 1 sets PEND (software interrupt). Reads 0.
  - 6 STATUS: read-only. bit4 = irq, bits3:0 = ivec.
  - 7 reserved: reads 0, writes ignored.
- **Writes.** Take effect on the clock edge where `io_sel & io_wr` is high.
- **Reads.** `io_rdata` is a combinational mux on `io_addr`, gated by `io_sel` (0 when not selected). Reads have no side effects.
- **Edge mode.** PEND[i] sets on Rise when EN[i]=1. Disabled sources never latch. PEND[i] clears on W1C or on an accepted iack for vector i+1.
- **Level mode.** PEND[i] = n & EN[i] every cycle. W1C and iack have no effect; the device must drop the line.
- **Priority.** The lowest index wins.
  - pend_next is the PEND value after this cycle's set/clear.
  - irq_next = GIE & |pend_next.
  - ivec_next = lowest set index of pend_next, plus 1, or 0 if none.
  - irq and ivec are registered from irq_next and ivec_next.
- **Acknowledge.** iack is accepted when `iack & ~hold & irq`. It clears PEND[ivec-1] in edge mode. An iack with irq low is ignored. GIE is not touched by hardware.
- **Simultaneous events on one bit, same cycle.**
  - Set (Rise or SET write) beats clear (W1C or iack); the bit stays pending.
  - An EN write and a Rise in the same cycle use the old EN.
- **POL or MODE changes.** A POL write may produce a Rise two cycles later. Software clears PEND after changing POL or MODE.
- **Reset.** Asynchronous. All of the following go to 0: s1, s2, p, PEND, EN, MODE, POL, GIE, irq, ivec. `io_rdata` then reads 0 for every register. A reset mid-interrupt drops irq immediately and discards all pending state.

## Timing
- **Source to irq.** A src edge meeting setup before clock edge k gives:
  - s1 at k, s2 at k+1, PEND set at k+2;
  - irq/ivec valid after edge k+2, i.e. 3-cycle latency.
  - An edge narrower than one clock may be missed. Source pulses must be at least 2 clocks wide.
- **Register writes to irq.** SET, EN and GIE writes affect irq after the same edge, i.e. 1-cycle latency.
- **After iack.**
  - irq drops after the iack edge if nothing else is pending.
  - Otherwise ivec changes to the next vector on that same edge.
  - No cycle ever presents a stale, already-acknowledged vector.
- **Vector changes while pending.** ivec may change while irq stays high if a higher-priority source arrives. The core samples both in the same cycle as iack.
- **Hold.** While hold is high, an asserted iack is held off. It is accepted once, on the first edge with hold low.

## Test plan
1. **Reset state.** Assert resetq=0 mid-run with irq high. Required: irq=0 and ivec=0 immediately, all register reads 0 after release, and src activity ignored while EN=0.
2. **Edge latency.** EN=0x01, GIE=1, src[0] rises before edge k. Required: irq=1 and ivec=1 after edge k+2. iack at k+5 gives irq=0 after k+5, and PEND reads 0.
3. **Priority and chaining.** EN=0x0C, then SET write 0x0C. Required: ivec=3 next cycle. iack gives ivec=4 on the next edge with irq still 1. A second iack gives irq=0.
4. **Level and polarity.** MODE[1]=1, POL[1]=1, EN[1]=1, GIE=1, src[1] driven low. Required: irq=1 and ivec=2. iack leaves irq=1. Driving src[1] high gives irq=0 three edges later.
5. **Collisions.** iack on vector 1 in the same cycle as a new Rise on src[0]. Required: PEND[0] stays 1 and irq stays 1. W1C 0x01 coinciding with a Rise also leaves PEND[0]=1.
6. **Hold and GIE.** iack held 3 cycles with hold=1, then 1 cycle with hold=0. Required: exactly one pending bit cleared. GIE=0 with PEND nonzero gives irq=0 and STATUS bit4=0.

Source files
------------

// File: rtl/chad_intc.sv
// ---------------------------------------------------------------------------
// chad_intc -- interrupt controller for the chad core.
//
// Synchronizes up to NSRC (1..15) asynchronous sources, latches rising edges
// or tracks levels per source, masks them with EN/GIE and presents the
// lowest-index pending source as vector 1..NSRC on irq/ivec. Vector 0 (reset)
// is never issued.
//
// Ports:
//   clk, resetq           clock, asynchronous active-low reset
//   hold                  core wait state; iack ignored while high
//   src[NSRC]             raw asynchronous interrupt lines
//   io_sel/io_addr/io_wr  I/O block select, register select, write strobe
//   io_wdata/io_rdata     I/O write data / combinational read data
//   irq, ivec[4]          registered interrupt request and vector
//   iack                  interrupt acknowledge from the core
//
// Register map (bit i = source i):
//   0 PEND (W1C)  1 EN  2 MODE (1=level)  3 POL (1=active-low)
//   4 GIE (bit0)  5 SET (write-only)  6 STATUS {irq, ivec}  7 reserved
// ---------------------------------------------------------------------------

// Per-source lane: synchronizer, polarity normalization, edge detect and
// the PEND bit with its set/clear resolution.
module chad_intc_lane (
    input  logic clk,
    input  logic resetq,
    input  logic i_src,
    input  logic i_pol,
    input  logic i_mode,
    input  logic i_en,        // EN before this cycle's write
    input  logic i_en_next,   // EN after this cycle's write
    input  logic i_set,       // SET write bit
    input  logic i_clr,       // W1C bit or accepted iack on this vector
    output logic o_pend,
    output logic o_pend_next
);
    logic r_s1, r_s2, r_p, r_pend;
    logic w_n, w_rise;

    assign w_n    = r_s2 ^ i_pol;
    assign w_rise = w_n & ~r_p;
    assign o_pend = r_pend;

    // Level mode follows the line every cycle; edge mode lets a set win
    // over a same-cycle clear so no event is ever lost.
    always_comb begin
        if (i_mode)
            o_pend_next = w_n & i_en_next;
        else if ((w_rise & i_en) | i_set)
            o_pend_next = 1'b1;
        else if (i_clr)
            o_pend_next = 1'b0;
        else
            o_pend_next = r_pend;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_p    <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_s1   <= i_src;
            r_s2   <= r_s1;
            r_p    <= w_n;
            r_pend <= o_pend_next;
        end
    end
endmodule

module chad_intc #(
    parameter int WIDTH = 18,
    parameter int NSRC  = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             hold,
    input  logic [NSRC-1:0]  src,
    input  logic             io_sel,
    input  logic [2:0]       io_addr,
    input  logic             io_wr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic [WIDTH-1:0] io_rdata,
    output logic             irq,
    output logic [3:0]       ivec,
    input  logic             iack
);
    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_EN     = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_POL    = 3'd3;
    localparam logic [2:0] A_GIE    = 3'd4;
    localparam logic [2:0] A_SET    = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic [NSRC-1:0] r_en, r_mode, r_pol;
    logic            r_gie, r_irq;
    logic [3:0]      r_ivec;

    logic            w_wr, w_ack, w_gie_next, w_irq_next;
    logic [3:0]      w_ivec_next;
    logic [NSRC-1:0] w_wbits, w_en_next, w_set, w_w1c, w_ackv;
    logic [NSRC-1:0] w_pend, w_pend_next;
    logic            w_unused_wdata;

    assign w_wr       = io_sel & io_wr;
    assign w_wbits    = io_wdata[NSRC-1:0];
    assign w_en_next  = (w_wr && io_addr == A_EN)  ? w_wbits     : r_en;
    assign w_gie_next = (w_wr && io_addr == A_GIE) ? io_wdata[0] : r_gie;
    assign w_set      = (w_wr && io_addr == A_SET)  ? w_wbits : '0;
    assign w_w1c      = (w_wr && io_addr == A_PEND) ? w_wbits : '0;
    assign w_unused_wdata = ^io_wdata[WIDTH-1:NSRC];

    // Only an iack against a live irq counts; it targets the vector the
    // core saw this cycle.
    assign w_ack = iack & ~hold & r_irq;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        assign w_ackv[i] = w_ack & (r_ivec == 4'(i + 1));

        chad_intc_lane u_lane (
            .clk         (clk),
            .resetq      (resetq),
            .i_src       (src[i]),
            .i_pol       (r_pol[i]),
            .i_mode      (r_mode[i]),
            .i_en        (r_en[i]),
            .i_en_next   (w_en_next[i]),
            .i_set       (w_set[i]),
            .i_clr       (w_w1c[i] | w_ackv[i]),
            .o_pend      (w_pend[i]),
            .o_pend_next (w_pend_next[i])
        );
    end

    // Priority from the post-update PEND so an acknowledged vector is never
    // presented again; scanning downward leaves the lowest index.
    always_comb begin
        w_ivec_next = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_pend_next[i]) w_ivec_next = 4'(i + 1);
    end

    assign w_irq_next = w_gie_next & (|w_pend_next);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_en   <= '0;
            r_mode <= '0;
            r_pol  <= '0;
            r_gie  <= 1'b0;
            r_irq  <= 1'b0;
            r_ivec <= 4'd0;
        end else begin
            r_en  <= w_en_next;
            r_gie <= w_gie_next;
            if (w_wr && io_addr == A_MODE) r_mode <= w_wbits;
            if (w_wr && io_addr == A_POL)  r_pol  <= w_wbits;
            r_irq  <= w_irq_next;
            r_ivec <= w_ivec_next;
        end
    end

    assign irq  = r_irq;
    assign ivec = r_ivec;

    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            case (io_addr)
                A_PEND:   io_rdata = WIDTH'(w_pend);
                A_EN:     io_rdata = WIDTH'(r_en);
                A_MODE:   io_rdata = WIDTH'(r_mode);
                A_POL:    io_rdata = WIDTH'(r_pol);
                A_GIE:    io_rdata = WIDTH'(r_gie);
                A_STATUS: io_rdata = WIDTH'({r_irq, r_ivec});
                default:  io_rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_chad_intc.sv
module tb_chad_intc;
    localparam int W  = 18;
    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          resetq = 1'b0;
    logic          hold = 1'b0;
    logic [NS-1:0] src = '0;
    logic          io_sel = 1'b0;
    logic [2:0]    io_addr = 3'd0;
    logic          io_wr = 1'b0;
    logic [W-1:0]  io_wdata = '0;
    logic [W-1:0]  io_rdata;
    logic          irq;
    logic [3:0]    ivec;
    logic          iack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: sampled source history, registers, outputs.
    logic [NS-1:0] m_s1, m_s2, m_p, m_pend, m_en, m_mode, m_pol;
    logic          m_gie, m_irq;
    logic [3:0]    m_ivec;

    chad_intc #(.WIDTH(W), .NSRC(NS)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .hold     (hold),
        .src      (src),
        .io_sel   (io_sel),
        .io_addr  (io_addr),
        .io_wr    (io_wr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .irq      (irq),
        .ivec     (ivec),
        .iack     (iack)
    );

    always #50 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_p = '0; m_pend = '0;
        m_en = '0; m_mode = '0; m_pol = '0;
        m_gie = 1'b0; m_irq = 1'b0; m_ivec = 4'd0;
    endtask

    // One clock of the controller's rules, from the inputs present now.
    task automatic model_step();
        logic [NS-1:0] lvl, rise, setb, clrb, en_new, pnew;
        logic wr;
        int k;
        wr   = io_sel & io_wr;
        lvl  = m_s2 ^ m_pol;
        rise = lvl & ~m_p;
        en_new = (wr && io_addr == 3'd1) ? io_wdata[NS-1:0] : m_en;
        setb = rise & m_en;
        if (wr && io_addr == 3'd5) setb = setb | io_wdata[NS-1:0];
        clrb = (wr && io_addr == 3'd0) ? io_wdata[NS-1:0] : '0;
        k = int'(m_ivec) - 1;
        if (iack && !hold && m_irq && k >= 0 && k < NS) clrb[k] = 1'b1;
        for (int i = 0; i < NS; i++)
            pnew[i] = m_mode[i] ? (lvl[i] & en_new[i]) : (setb[i] | (m_pend[i] & ~clrb[i]));
        if (wr && io_addr == 3'd2) m_mode = io_wdata[NS-1:0];
        if (wr && io_addr == 3'd3) m_pol  = io_wdata[NS-1:0];
        if (wr && io_addr == 3'd4) m_gie  = io_wdata[0];
        m_en   = en_new;
        m_pend = pnew;
        m_p    = lvl;
        m_s2   = m_s1;
        m_s1   = src;
        m_irq  = m_gie && (pnew != '0);
        m_ivec = 4'd0;
        for (int i = NS - 1; i >= 0; i--)
            if (pnew[i]) m_ivec = 4'(i + 1);
    endtask

    function automatic logic [W-1:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0: return W'(m_pend);
            3'd1: return W'(m_en);
            3'd2: return W'(m_mode);
            3'd3: return W'(m_pol);
            3'd4: return W'(m_gie);
            3'd6: return W'({m_irq, m_ivec});
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        io_sel = 1'b1; io_wr = 1'b1; io_addr = 3'(a); io_wdata = W'(d);
        tick();
        io_sel = 1'b0; io_wr = 1'b0; io_wdata = '0;
    endtask

    task automatic rd(input int a, output logic [W-1:0] v);
        io_sel = 1'b1; io_wr = 1'b0; io_addr = 3'(a);
        #1;
        v = io_rdata;
        io_sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        wr(1, 'h01); wr(4, 1); wr(5, 'h01);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd1) begin
            n_err++; $display("FAIL reset_pre irq=%0b ivec=%0d want 1/1", irq, ivec);
        end
        resetq = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (irq !== 1'b0 || ivec !== 4'd0) begin
            n_err++; $display("FAIL reset_async irq=%0b ivec=%0d want 0/0", irq, ivec);
        end
        #2 resetq = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(a, v);
            n_cmp++;
            if (v !== '0) begin n_err++; $display("FAIL reset_rd addr=%0d got %h want 0", a, v); end
        end
        for (int c = 0; c < 10; c++) begin
            src = NS'($urandom);
            tick();
            n_cmp++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL reset_en0 irq=%0b want 0", irq); end
        end
        rd(0, v);
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL reset_pend got %h want 0", v); end
        src = '0;
        repeat (3) tick();
    endtask

    task automatic test_edge_latency();
        logic [W-1:0] v;
        wr(1, 'h01); wr(4, 1);
        src[0] = 1'b1;
        tick(); tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL edge_early irq=%0b want 0", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd1) begin
            n_err++; $display("FAIL edge_lat irq=%0b ivec=%0d want 1/1", irq, ivec);
        end
        tick(); tick();
        iack = 1'b1; tick(); iack = 1'b0;
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b0 || v !== '0) begin
            n_err++; $display("FAIL edge_ack irq=%0b pend=%h want 0/0", irq, v);
        end
        src[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_priority();
        logic [W-1:0] v;
        wr(1, 'h0C); wr(5, 'h0C);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd3) begin
            n_err++; $display("FAIL prio_first irq=%0b ivec=%0d want 1/3", irq, ivec);
        end
        iack = 1'b1; tick();
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd4) begin
            n_err++; $display("FAIL prio_chain irq=%0b ivec=%0d want 1/4", irq, ivec);
        end
        tick(); iack = 1'b0;
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b0 || v !== '0) begin
            n_err++; $display("FAIL prio_done irq=%0b pend=%h want 0/0", irq, v);
        end
    endtask

    task automatic test_level_pol();
        logic [W-1:0] v;
        wr(2, 'h02); wr(3, 'h02);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_masked irq=%0b want 0", irq); end
        wr(1, 'h02);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd2) begin
            n_err++; $display("FAIL lvl_on irq=%0b ivec=%0d want 1/2", irq, ivec);
        end
        iack = 1'b1; tick(); iack = 1'b0;
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd2 || v !== W'('h02)) begin
            n_err++; $display("FAIL lvl_ack irq=%0b ivec=%0d pend=%h want 1/2/02", irq, ivec, v);
        end
        src[1] = 1'b1;
        tick(); tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_hold irq=%0b want 1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_drop irq=%0b want 0", irq); end
        wr(1, 0); wr(2, 0); wr(3, 0);
        src[1] = 1'b0;
        repeat (3) tick();
        wr(0, 'hFF);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_clean irq=%0b want 0", irq); end
    endtask

    task automatic test_collision();
        logic [W-1:0] v;
        wr(1, 'h01); wr(5, 'h01);
        src[0] = 1'b1;
        tick(); tick();
        iack = 1'b1; tick(); iack = 1'b0;
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd1 || v !== W'('h01)) begin
            n_err++; $display("FAIL col_iack irq=%0b ivec=%0d pend=%h want 1/1/01", irq, ivec, v);
        end
        src[0] = 1'b0;
        repeat (3) tick();
        src[0] = 1'b1;
        tick(); tick();
        wr(0, 'h01);
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b1 || v !== W'('h01)) begin
            n_err++; $display("FAIL col_w1c irq=%0b pend=%h want 1/01", irq, v);
        end
        src[0] = 1'b0;
        repeat (3) tick();
        wr(0, 'h01);
        rd(0, v);
        n_cmp++;
        if (irq !== 1'b0 || v !== '0) begin
            n_err++; $display("FAIL col_clear irq=%0b pend=%h want 0/0", irq, v);
        end
    endtask

    task automatic test_hold_gie();
        logic [W-1:0] v;
        wr(1, 'h06); wr(5, 'h06);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd2) begin
            n_err++; $display("FAIL hold_pre irq=%0b ivec=%0d want 1/2", irq, ivec);
        end
        hold = 1'b1; iack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            rd(0, v);
            n_cmp++;
            if (v !== W'('h06)) begin n_err++; $display("FAIL hold_wait pend=%h want 06", v); end
        end
        hold = 1'b0; tick(); iack = 1'b0;
        rd(0, v);
        n_cmp++;
        if (v !== W'('h04) || irq !== 1'b1 || ivec !== 4'd3) begin
            n_err++; $display("FAIL hold_once pend=%h irq=%0b ivec=%0d want 04/1/3", v, irq, ivec);
        end
        wr(4, 0);
        rd(6, v);
        n_cmp++;
        if (irq !== 1'b0 || v !== W'('h03)) begin
            n_err++; $display("FAIL gie_off irq=%0b status=%h want 0/03", irq, v);
        end
        wr(4, 1);
        n_cmp++;
        if (irq !== 1'b1 || ivec !== 4'd3) begin
            n_err++; $display("FAIL gie_on irq=%0b ivec=%0d want 1/3", irq, ivec);
        end
        wr(0, 'hFF);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL gie_clean irq=%0b want 0", irq); end
    endtask

    task automatic test_random();
        logic [2:0] a;
        for (int c = 0; c < 800; c++) begin
            src     = src ^ (NS'($urandom) & NS'($urandom));
            io_sel  = ($urandom_range(0, 3) != 0);
            io_wr   = ($urandom_range(0, 3) == 0);
            io_addr = 3'($urandom_range(0, 7));
            io_wdata = W'($urandom);
            if (io_addr == 3'd4) io_wdata[0] = ($urandom_range(0, 3) != 0);
            iack = ($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (irq !== m_irq || ivec !== m_ivec) begin
                n_err++;
                $display("FAIL rand_out cyc=%0d irq=%0b ivec=%0d want %0b/%0d", c, irq, ivec, m_irq, m_ivec);
            end
            a = 3'($urandom_range(0, 7));
            io_wr = 1'b0; io_sel = 1'b1; io_addr = a;
            #1;
            n_cmp++;
            if (io_rdata !== model_rd(a)) begin
                n_err++;
                $display("FAIL rand_rd cyc=%0d addr=%0d got %h want %h", c, a, io_rdata, model_rd(a));
            end
        end
        io_sel = 1'b0; io_wr = 1'b0; iack = 1'b0; hold = 1'b0; src = '0;
        repeat (3) tick();
    endtask

    initial begin
        model_reset();
        #20 resetq = 1'b1;
        test_reset();
        test_edge_latency();
        test_priority();
        test_level_pol();
        test_collision();
        test_hold_gie();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
